rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised N-input, registered stream multiplexer with valid/ready handshakes.
- Successor to the team's fixed 4:1 combinational mux. Adds the following:
  - arbitrary channel count and width;
  - round-robin or fixed-priority arbitration;
  - a manual-select override;
  - a one-entry output register.
- Used wherever several producers share one consumer, e.g. memory-request or UART-TX sources feeding a single port.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 4, number of input channels (2..16).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SEL_W (localparam), $clog2(NUM_CH), width of channel-index signals.

Ports:
- CLK  input  1  rising-edge clock; single clock domain.
- RST_N  input  1  synchronous, active-low reset.
- IN_DATA  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  input  NUM_CH  per-channel valid.
- IN_READY  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- FORCE_EN  input  1  1 = ignore arbitration and consider only channel FORCE_SEL.
- FORCE_SEL  input  SEL_W  manually selected channel when FORCE_EN = 1.
- OUT_DATA  output  WIDTH  registered output data.
- OUT_VALID  output  1  output register holds a word.
- OUT_READY  input  1  consumer accepts the word.
- OUT_CH  output  SEL_W  source channel index of OUT_DATA.

Behaviour:
- Reset is synchronous, active-low, one clock. RST_N sampled low at a rising edge forces:
  - OUT_VALID = 0, OUT_DATA = 0, OUT_CH = 0;
  - RR pointer = 0.
- While RST_N = 0, IN_READY = all zeros (combinationally gated).
- Reset mid-transfer discards the held word; no channel is acknowledged that cycle.
- load_en = !OUT_VALID | OUT_READY. The output register can accept a new word when empty or when being drained in the same cycle.
- Grant (combinational, from IN_VALID and pointer):
  - FORCE_EN = 1: grant = FORCE_SEL if IN_VALID[FORCE_SEL], else none. FORCE_SEL >= NUM_CH means no grant.
  - FORCE_EN = 0, RR = 0: lowest-index valid channel.
  - FORCE_EN = 0, RR = 1: first valid channel searching ptr, ptr+1, ..., wrapping modulo NUM_CH.
- IN_READY[i] = load_en & grant_valid & (grant == i) & RST_N. Ready never depends on IN_VALID of other channels beyond the grant logic.
- A transfer occurs on channel i when IN_VALID[i] & IN_READY[i]. At that edge:
  - OUT_DATA <= channel i data; OUT_CH <= i; OUT_VALID <= 1.
  - If RR = 1 and FORCE_EN = 0, ptr <= (i+1) mod NUM_CH.
- Forced grants do not move the pointer.
- Output drained with no new transfer (OUT_VALID & OUT_READY, no grant): OUT_VALID <= 0. OUT_DATA and OUT_CH hold their last values.
- Stall (OUT_VALID & !OUT_READY): OUT_DATA, OUT_CH and OUT_VALID are held stable; all IN_READY = 0.
- Simultaneous drain and load: the new word replaces the old in the same edge. Sustained throughput is 1 word/cycle.
- Latency: input accepted at edge n appears on OUT_DATA/OUT_VALID after edge n (1 cycle).
- Fairness: with all channels continuously valid and RR = 1, grants rotate 0,1,...,NUM_CH-1,0,... Each channel is served at least once per NUM_CH transfers.
- No combinational path from IN_DATA to OUT_DATA.
- The only paths from OUT_READY to IN_READY pass through load_en.

Test Plan:
- Reset: hold RST_N = 0 for 3 cycles with all IN_VALID = 1 -> OUT_VALID = 0, OUT_DATA = 0, IN_READY = 0000. After release, first grant goes to ch0.
- Round-robin fairness (RR = 1, NUM_CH = 4, WIDTH = 32): all valid, IN_DATA ch i = 0xA0+i, OUT_READY = 1 -> OUT_DATA sequence A0, A1, A2, A3, A0 on consecutive cycles; OUT_CH 0,1,2,3,0.
- Fixed priority (RR = 0): ch1 and ch3 valid continuously -> ch1 always granted. ch3 is granted only after ch1 deasserts, with OUT_CH = 3 one cycle later.
- Backpressure: OUT_READY = 0 for 4 cycles with output holding 0xA2 -> OUT_DATA = 0xA2 stable and IN_READY = 0000 throughout. When OUT_READY = 1, the next word loads in the same edge with no bubble.
- Force mode: FORCE_EN = 1, FORCE_SEL = 2, all valid -> only ch2 is granted, with the pointer unchanged. Then FORCE_SEL = 3 while ch3 is invalid -> no transfer, and OUT_VALID drops after the drain.
- Sparse/wrap: pointer = 3, only ch0 valid -> ch0 granted (wrap-around), then pointer = 1. Reset asserted while OUT_VALID = 1 -> OUT_VALID = 0 next cycle.

Source files
------------

// File: rtl/rr_stream_mux.sv
// Registered N:1 stream multiplexer with round-robin or fixed-priority arbitration,
// a manual-select override and a one-entry output register.
module rr_stream_mux #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  parameter  int RR     = 1,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_CH*WIDTH-1:0] IN_DATA,
  input  logic [NUM_CH-1:0]       IN_VALID,
  output logic [NUM_CH-1:0]       IN_READY,
  input  logic                    FORCE_EN,
  input  logic [SEL_W-1:0]        FORCE_SEL,
  output logic [WIDTH-1:0]        OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [SEL_W-1:0]        OUT_CH
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic [NUM_CH-1:0] force_hit_s;
  logic [NUM_CH-1:0] upper_s;
  logic [NUM_CH-1:0] req_s;
  logic              grant_valid_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic [WIDTH-1:0]  grant_data_s;
  logic              load_en_s;
  logic              xfer_s;

  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = mask[i] ? SEL_W'(i) : idx;
    end
    return idx;
  endfunction

  // Request masks: forced channel, and valid channels at or above the RR pointer
  always_comb begin
    force_hit_s = '0;
    upper_s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      force_hit_s[i] = IN_VALID[i] & (FORCE_SEL == SEL_W'(i));
      upper_s[i]     = IN_VALID[i] & (SEL_W'(i) >= ptr_q);
    end
  end

  // Round-robin wraps to the lowest valid channel when nothing at/above ptr is valid
  always_comb begin
    req_s = IN_VALID;
    if (FORCE_EN) begin
      req_s = force_hit_s;
    end else if ((RR != 0) && (|upper_s)) begin
      req_s = upper_s;
    end else begin
      req_s = IN_VALID;
    end
    grant_valid_s = |req_s;
    grant_idx_s   = lowest_idx(req_s);
  end

  // Data selection from the granted channel
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_data_s = grant_data_s |
                     (IN_DATA[i*WIDTH +: WIDTH] & {WIDTH{grant_idx_s == SEL_W'(i)}});
    end
  end

  assign load_en_s = ~out_valid_q | OUT_READY;
  assign xfer_s    = load_en_s & grant_valid_s & RST_N;

  // One-hot ready towards the granted producer
  always_comb begin
    IN_READY = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      IN_READY[i] = xfer_s & (grant_idx_s == SEL_W'(i));
    end
  end

  // Next-state for the output register and arbitration pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_s;
      out_ch_d    = grant_idx_s;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s && (RR != 0) && !FORCE_EN) begin
      ptr_d = (grant_idx_s == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx_s + SEL_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a queue-free behavioural model plus directed literals.
module tb_rr_stream_mux;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*W-1:0]  in_data = '0;
  logic [NCH-1:0]    in_valid = '0;
  logic              force_en = 1'b0;
  logic [1:0]        force_sel = 2'd0;
  logic              out_ready = 1'b1;

  logic [NCH-1:0]    a_in_ready, b_in_ready;
  logic [W-1:0]      a_out_data, b_out_data;
  logic              a_out_valid, b_out_valid;
  logic [1:0]        a_out_ch, b_out_ch;

  int errors = 0;
  int checks = 0;

  bit          check_en = 1'b0;
  bit          m_valid [2];
  logic [W-1:0] m_data [2];
  int          m_ch [2];
  int          m_ptr [2];

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(W), .NUM_CH(NCH), .RR(1)) dut_rr (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(a_in_ready), .FORCE_EN(force_en), .FORCE_SEL(force_sel),
    .OUT_DATA(a_out_data), .OUT_VALID(a_out_valid), .OUT_READY(out_ready),
    .OUT_CH(a_out_ch));

  rr_stream_mux #(.WIDTH(W), .NUM_CH(NCH), .RR(0)) dut_fp (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(b_in_ready), .FORCE_EN(force_en), .FORCE_SEL(force_sel),
    .OUT_DATA(b_out_data), .OUT_VALID(b_out_valid), .OUT_READY(out_ready),
    .OUT_CH(b_out_ch));

  // Which channel the arbitration rules pick, -1 for none
  function automatic int mgrant(input bit rr, input int ptr, input logic [NCH-1:0] v,
                                input logic fe, input int fs);
    int c;
    if (fe) return (fs < NCH && v[fs]) ? fs : -1;
    for (int k = 0; k < NCH; k++) begin
      c = rr ? (ptr + k) % NCH : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int g_of(input int u);
    return mgrant(u == 0, m_ptr[u], in_valid, force_en, int'(force_sel));
  endfunction

  function automatic logic [W-1:0] ch_data(input int g);
    return W'(in_data >> (W * g));
  endfunction

  function automatic logic [NCH-1:0] exp_ready(input int u);
    int g;
    g = g_of(u);
    if (rst_n && (!m_valid[u] || out_ready) && g >= 0) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance on each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      check_en <= 1'b1;
      for (int u = 0; u < 2; u++) begin
        m_valid[u] <= 1'b0;
        m_data[u]  <= '0;
        m_ch[u]    <= 0;
        m_ptr[u]   <= 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if ((!m_valid[u] || out_ready) && g_of(u) >= 0) begin
          m_valid[u] <= 1'b1;
          m_data[u]  <= ch_data(g_of(u));
          m_ch[u]    <= g_of(u);
          if (u == 0 && !force_en) m_ptr[u] <= (g_of(u) + 1) % NCH;
        end else if (out_ready) begin
          m_valid[u] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("rr_ready", W'(a_in_ready), W'(exp_ready(0)));
      chk("rr_valid", W'(a_out_valid), W'(m_valid[0]));
      chk("rr_data",  a_out_data, m_data[0]);
      chk("rr_ch",    W'(a_out_ch), W'(m_ch[0]));
      chk("fp_ready", W'(b_in_ready), W'(exp_ready(1)));
      chk("fp_valid", W'(b_out_valid), W'(m_valid[1]));
      chk("fp_data",  b_out_data, m_data[1]);
      chk("fp_ch",    W'(b_out_ch), W'(m_ch[1]));
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic ne();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
    in_valid = 4'b1111;

    // reset held with all channels valid
    repeat (3) begin
      ne();
      chk("rst_valid", W'(a_out_valid), 32'd0);
      chk("rst_data", a_out_data, 32'd0);
      chk("rst_ready", W'(a_in_ready), 32'd0);
    end
    go(); rst_n = 1'b1;
    ne();
    chk("first_grant_rr", W'(a_in_ready), 32'h1);
    chk("first_grant_fp", W'(b_in_ready), 32'h1);

    // round-robin rotation, fixed priority stays on ch0
    for (int k = 0; k < 7; k++) begin
      go();
      if (k == 6) out_ready = 1'b0;
      ne();
      chk("rr_seq_data", a_out_data, 32'hA0 + 32'(k % 4));
      chk("rr_seq_ch", W'(a_out_ch), 32'(k % 4));
      chk("fp_seq_ch", W'(b_out_ch), 32'd0);
    end

    // backpressure holding 0xA2
    repeat (3) begin
      go(); ne();
      chk("bp_data", a_out_data, 32'hA2);
      chk("bp_valid", W'(a_out_valid), 32'd1);
      chk("bp_ready_rr", W'(a_in_ready), 32'd0);
      chk("bp_ready_fp", W'(b_in_ready), 32'd0);
    end
    go(); out_ready = 1'b1;
    ne();
    chk("bp_release_ready", W'(a_in_ready), 32'h8);
    go(); ne();
    chk("bp_nobubble_data", a_out_data, 32'hA3);
    chk("bp_nobubble_valid", W'(a_out_valid), 32'd1);

    // fixed priority: ch1 beats ch3
    go(); in_valid = 4'b1010;
    ne();
    repeat (3) begin
      go(); ne();
      chk("fp_ch1", W'(b_out_ch), 32'd1);
      chk("fp_ch1_data", b_out_data, 32'hA1);
    end
    go(); in_valid = 4'b1000;
    ne();
    chk("fp_ch3_ready", W'(b_in_ready), 32'h8);
    go(); ne();
    chk("fp_ch3", W'(b_out_ch), 32'd3);
    chk("fp_ch3_data", b_out_data, 32'hA3);

    // force mode from a fresh pointer
    go(); rst_n = 1'b0; in_valid = 4'b0000;
    ne();
    go(); rst_n = 1'b1; force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b1111;
    ne();
    chk("force_ready", W'(a_in_ready), 32'h4);
    repeat (3) begin
      go(); ne();
      chk("force_ch", W'(a_out_ch), 32'd2);
      chk("force_data", a_out_data, 32'hA2);
      chk("force_ready_hold", W'(a_in_ready), 32'h4);
    end
    go(); force_en = 1'b0;
    ne();
    chk("force_ptr_kept", W'(a_in_ready), 32'h1);
    go(); force_en = 1'b1; force_sel = 2'd3; in_valid = 4'b0111;
    ne();
    chk("force_inv_ch", W'(a_out_ch), 32'd0);
    chk("force_inv_ready", W'(a_in_ready), 32'd0);
    go(); ne();
    chk("force_drain_valid", W'(a_out_valid), 32'd0);
    chk("force_drain_data", a_out_data, 32'hA0);

    // sparse requests and wrap-around
    go(); force_en = 1'b0; in_valid = 4'b0100;
    ne();
    chk("sparse_ready", W'(a_in_ready), 32'h4);
    go(); in_valid = 4'b0001;
    ne();
    chk("wrap_ready", W'(a_in_ready), 32'h1);
    go(); in_valid = 4'b1111;
    ne();
    chk("wrap_ch", W'(a_out_ch), 32'd0);
    chk("wrap_ptr", W'(a_in_ready), 32'h2);
    go(); rst_n = 1'b0;
    ne();
    chk("midrst_ready", W'(a_in_ready), 32'd0);
    go(); ne();
    chk("midrst_valid", W'(a_out_valid), 32'd0);
    chk("midrst_data", a_out_data, 32'd0);

    // randomized traffic
    go(); rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      go();
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = $urandom;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      force_en  = ($urandom_range(0, 9) == 0);
      force_sel = 2'($urandom);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    go(); ne();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
